spi_m_cs: RTL and testbench
===========================

# spi_m_cs

Transaction controller placed directly upstream of the byte-level SPI master engine. It accepts multi-byte transactions from the host side and owns the active-low chip select, holding it low across all bytes of a transaction. It feeds bytes to the engine one at a time, forwards each received byte back with its index, and enforces a minimum CS-high gap between transactions.

## Interface
- MAX_BYTES_PER_CS, default 2: maximum number of bytes per transaction; count width CW = $clog2(MAX_BYTES_PER_CS+1).
- CS_INACTIVE_CLKS, default 1: minimum number of i_Clk cycles CS is held high after a transaction; must be at least 1.
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Rst_L  in  1  reset, asynchronous and active-low.
- i_TX_Count  in  CW  byte count for the transaction; sampled only with the first i_TX_DV of a transaction.
- i_TX_Byte  in  8  host byte; sampled when i_TX_DV is high.
- i_TX_DV  in  1  single-cycle valid strobe; ignored unless o_TX_Ready is high in the same cycle.
- o_TX_Ready  out  1  block can accept a byte this cycle (combinational).
- o_RX_Count  out  CW  index of the last received byte; 0 is the first byte of the transaction.
- o_RX_DV  out  1  single-cycle pulse with o_RX_Byte.
- o_RX_Byte  out  8  received byte.
- o_Eng_TX_Byte  out  8  byte sent to the engine.
- o_Eng_TX_DV  out  1  single-cycle strobe to the engine.
- i_Eng_TX_Ready  in  1  engine idle. Contract: it falls no later than 1 cycle after o_Eng_TX_DV, and stays low until the byte completes.
- i_Eng_RX_DV  in  1  engine received-byte pulse.
- i_Eng_RX_Byte  in  8  engine received byte.
- o_SPI_CS_n  out  1  chip select, active-low.

## Operation
- Reset values:
  - o_SPI_CS_n=1.
  - o_Eng_TX_DV=0, o_Eng_TX_Byte=0.
  - o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0.
  - Internal counters are 0 and the state is IDLE.
- **Reset mid-transaction:** CS rises immediately (asynchronously) and all state is discarded. No o_RX_DV is produced for a partial byte.
- **States:** IDLE, TRANSFER, CS_INACTIVE.
- **o_TX_Ready** = (IDLE & i_Eng_TX_Ready) | (TRANSFER & tx_left≠0 & i_Eng_TX_Ready & ~o_Eng_TX_DV). It is 0 in CS_INACTIVE.
- **IDLE, on an accepted i_TX_DV:**
  - Latch the count: 0 becomes 1; values above MAX_BYTES_PER_CS are clamped to MAX_BYTES_PER_CS.
  - Set tx_left = count−1 and rx_idx = 0.
  - Drive o_SPI_CS_n low, forward the byte, go to TRANSFER.
- **TRANSFER, on an accepted i_TX_DV:** forward the byte and decrement tx_left.
- **TRANSFER, on i_Eng_RX_DV:**
  - Register o_RX_Byte ← i_Eng_RX_Byte and o_RX_Count ← rx_idx.
  - Pulse o_RX_DV, then increment rx_idx.
- **TRANSFER exit:** when tx_left=0, rx_idx=count, i_Eng_TX_Ready=1 and o_Eng_TX_DV=0:
  - Drive o_SPI_CS_n high, load the gap counter with CS_INACTIVE_CLKS, go to CS_INACTIVE.
- **CS_INACTIVE:** decrement the gap counter each cycle; at 1 → IDLE.
- **Host stall:** CS stays low indefinitely while the host has not supplied the next byte (tx_left>0).
- **i_Eng_RX_DV outside TRANSFER:** ignored; no o_RX_DV.
- **Counters:** all are CW-bit and never wrap in legal operation; rx_idx saturates at count.

## Timing
- Accept at cycle N (i_TX_DV & o_TX_Ready) → o_Eng_TX_DV=1 with o_Eng_TX_Byte at N+1 (registered, 1 cycle).
- First byte: o_SPI_CS_n falls at N+1, the same edge as o_Eng_TX_DV.
- o_TX_Ready is masked during the o_Eng_TX_DV cycle. This guarantees at most one strobe per engine byte.
- i_Eng_RX_DV at cycle M → o_RX_DV at M+1.
- Last byte: if i_Eng_TX_Ready is high at cycle K with the exit conditions met, o_SPI_CS_n rises at K+1.
- CS stays high for exactly CS_INACTIVE_CLKS cycles, then o_TX_Ready can assert.
- Minimum CS-high time between back-to-back transactions = CS_INACTIVE_CLKS+1 cycles.

## Test plan
The bench uses a behavioural engine model: ready drops 1 cycle after DV, a 20-cycle byte time, and loopback RX = TX ^ 8'hFF.
- **Single byte:** count=1, byte 8'hA5 → CS low for one byte only; o_RX_DV once with o_RX_Byte=8'h5A and o_RX_Count=0; CS high for ≥2 cycles, then o_TX_Ready=1.
- **Multi-byte (MAX_BYTES_PER_CS=4):** count=3, bytes 8'h01, 8'h02, 8'h03 → CS stays continuously low; three o_Eng_TX_DV pulses; RX 8'hFE, 8'hFD, 8'hFC with indices 0, 1, 2; CS rises once.
- **Count boundaries:** count=0 → treated as 1 byte. count=7 with MAX=4 → exactly 4 bytes, then CS high; a 5th i_TX_DV starts a new transaction only after the gap.
- **Ignored strobes:** i_TX_DV pulsed while o_TX_Ready=0 (mid-byte and during CS_INACTIVE) → no o_Eng_TX_DV, and the counters are unchanged.
- **Reset mid-transfer:** i_Rst_L low during byte 2 of 3 → o_SPI_CS_n=1 asynchronously and all outputs at reset values; after release, a count=1 transaction completes normally.
- **Host stall:** count=2, second byte delayed 100 cycles → CS held low throughout, and o_TX_Ready stays high until the byte is supplied.

Source files
------------

// File: rtl/spi_m_cs_if.sv
// Bundle of host-side, engine-side and chip-select signals for spi_m_cs.
// The slave modport is the controller's view; master is the surrounding
// system (host plus byte engine).
interface spi_m_cs_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

  // Host side
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;

  // Byte engine side
  logic [7:0]    o_Eng_TX_Byte;
  logic          o_Eng_TX_DV;
  logic          i_Eng_TX_Ready;
  logic          i_Eng_RX_DV;
  logic [7:0]    i_Eng_RX_Byte;

  // Chip select, active-low
  logic          o_SPI_CS_n;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV,
    input  i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    output o_Eng_TX_Byte, o_Eng_TX_DV, o_SPI_CS_n
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV,
    output i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    input  o_Eng_TX_Byte, o_Eng_TX_DV, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_m_cs.sv
// Multi-byte SPI transaction controller sitting in front of a byte-level
// SPI master engine. Holds chip select low across every byte of a
// transaction, hands bytes to the engine one at a time, returns each
// received byte with its index, and enforces a minimum CS-high gap.
module spi_m_cs #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1
) (
  input logic      i_Clk,
  input logic      i_Rst_L,
  spi_m_cs_if.slave bus
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int GW = (CS_INACTIVE_CLKS < 2) ? 1 : $clog2(CS_INACTIVE_CLKS + 1);

  typedef enum logic [1:0] {IDLE, TRANSFER, CS_INACTIVE} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] tx_left_q;
  logic [CW-1:0] rx_idx_q;
  logic [GW-1:0] gap_q;
  logic          cs_n_q;
  logic          eng_dv_q;
  logic [7:0]    eng_byte_q;
  logic          rx_dv_q;
  logic [7:0]    rx_byte_q;
  logic [CW-1:0] rx_count_q;

  logic [CW-1:0] count_d;
  logic          tx_ready;
  logic          tx_accept;
  logic          xfer_done;

  // Normalise the requested byte count: zero means one byte, oversize clamps.
  always_comb begin
    count_d = bus.i_TX_Count;
    if (bus.i_TX_Count == '0)
      count_d = CW'(1);
    else if (bus.i_TX_Count > CW'(MAX_BYTES_PER_CS))
      count_d = CW'(MAX_BYTES_PER_CS);
  end

  // Ready is masked during the strobe cycle so the engine never sees two
  // strobes before it has had a chance to drop its own ready.
  assign tx_ready = ((state_q == IDLE) && bus.i_Eng_TX_Ready) ||
                    ((state_q == TRANSFER) && (tx_left_q != '0) &&
                     bus.i_Eng_TX_Ready && !eng_dv_q);
  assign tx_accept = bus.i_TX_DV && tx_ready;

  // Last byte sent and received, and the engine has gone idle again.
  assign xfer_done = (tx_left_q == '0) && (rx_idx_q == count_q) &&
                     bus.i_Eng_TX_Ready && !eng_dv_q;

  // Transaction FSM with all outputs registered; reset raises CS at once.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      count_q    <= '0;
      tx_left_q  <= '0;
      rx_idx_q   <= '0;
      gap_q      <= '0;
      cs_n_q     <= 1'b1;
      eng_dv_q   <= 1'b0;
      eng_byte_q <= '0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      rx_count_q <= '0;
    end else begin
      eng_dv_q <= 1'b0;
      rx_dv_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_accept) begin
            count_q    <= count_d;
            tx_left_q  <= count_d - CW'(1);
            rx_idx_q   <= '0;
            cs_n_q     <= 1'b0;
            eng_dv_q   <= 1'b1;
            eng_byte_q <= bus.i_TX_Byte;
            state_q    <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (tx_accept) begin
            eng_dv_q   <= 1'b1;
            eng_byte_q <= bus.i_TX_Byte;
            tx_left_q  <= tx_left_q - CW'(1);
          end
          if (bus.i_Eng_RX_DV) begin
            rx_byte_q  <= bus.i_Eng_RX_Byte;
            rx_count_q <= rx_idx_q;
            rx_dv_q    <= 1'b1;
            if (rx_idx_q != count_q)
              rx_idx_q <= rx_idx_q + CW'(1);
          end
          if (xfer_done) begin
            cs_n_q  <= 1'b1;
            gap_q   <= GW'(CS_INACTIVE_CLKS);
            state_q <= CS_INACTIVE;
          end
        end
        CS_INACTIVE: begin
          gap_q <= gap_q - GW'(1);
          if (gap_q <= GW'(1))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_TX_Ready    = tx_ready;
  assign bus.o_RX_Count    = rx_count_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_Eng_TX_Byte = eng_byte_q;
  assign bus.o_Eng_TX_DV   = eng_dv_q;
  assign bus.o_SPI_CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_m_cs.sv
// Bench for spi_m_cs: behavioural byte engine (20-cycle byte, inverted
// loopback), table of transactions plus hand-written reset and stall runs,
// with an expected-RX scoreboard.
module tb_spi_m_cs;
  localparam int MAXB = 4;
  localparam int GAP  = 1;
  localparam int CW   = $clog2(MAXB + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_m_cs_if #(.MAX_BYTES_PER_CS(MAXB)) bus();

  spi_m_cs #(.MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(GAP)) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  // Engine model: ready drops the cycle after the strobe, byte takes 20 cycles.
  logic       e_ready   = 1'b1;
  logic       e_busy    = 1'b0;
  int         e_timer   = 0;
  logic [7:0] e_byte    = 8'h00;
  logic       e_rx_dv   = 1'b0;
  logic [7:0] e_rx_byte = 8'h00;

  assign bus.i_Eng_TX_Ready = e_ready;
  assign bus.i_Eng_RX_DV    = e_rx_dv;
  assign bus.i_Eng_RX_Byte  = e_rx_byte;

  always @(posedge clk) begin
    e_rx_dv <= 1'b0;
    if (e_busy) begin
      e_timer <= e_timer - 1;
      if (e_timer == 1) begin
        e_busy    <= 1'b0;
        e_ready   <= 1'b1;
        e_rx_dv   <= 1'b1;
        e_rx_byte <= e_byte ^ 8'hFF;
      end
    end else if (bus.o_Eng_TX_DV) begin
      e_busy  <= 1'b1;
      e_ready <= 1'b0;
      e_timer <= 20;
      e_byte  <= bus.o_Eng_TX_Byte;
    end
  end

  // Output monitors, sampled on the falling edge.
  logic          cs_prev     = 1'b1;
  int            cs_rise_cnt = 0;
  int            cs_fall_cnt = 0;
  int            eng_dv_cnt  = 0;
  int            rx_seen     = 0;
  logic [7:0]    obs_b [0:255];
  logic [CW-1:0] obs_c [0:255];

  always @(negedge clk) begin
    cs_prev <= bus.o_SPI_CS_n;
    if (!cs_prev && bus.o_SPI_CS_n) cs_rise_cnt <= cs_rise_cnt + 1;
    if (cs_prev && !bus.o_SPI_CS_n) cs_fall_cnt <= cs_fall_cnt + 1;
    if (bus.o_Eng_TX_DV) eng_dv_cnt <= eng_dv_cnt + 1;
    if (bus.o_RX_DV) begin
      obs_b[rx_seen[7:0]] <= bus.o_RX_Byte;
      obs_c[rx_seen[7:0]] <= bus.o_RX_Count;
      rx_seen <= rx_seen + 1;
    end
  end

  typedef struct packed {
    logic [7:0]    b;
    logic [CW-1:0] idx;
  } rx_t;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [7:0]    first;
    int            nexp;
    logic [7:0]    rx0;
  } vec_t;

  rx_t  exp_q[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_idx   = 0;
  int   snap_e, snap_r, snap_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, expected event never arrived", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [CW-1:0] cnt, input int idx,
                      input string name);
    int t = 0;
    while (!bus.o_TX_Ready && t < 300) begin
      tick();
      t++;
    end
    if (!bus.o_TX_Ready) begin
      timeout_fail({name, " tx_ready"});
      return;
    end
    bus.i_TX_DV    = 1'b1;
    bus.i_TX_Byte  = b;
    bus.i_TX_Count = cnt;
    exp_q.push_back('{b: b ^ 8'hFF, idx: CW'(idx)});
    tick();
    bus.i_TX_DV = 1'b0;
  endtask

  // A strobe offered while ready is low must be dropped.
  task automatic stray(input string name);
    chk({name, " ready_low"}, 32'(bus.o_TX_Ready), 32'd0);
    bus.i_TX_DV    = 1'b1;
    bus.i_TX_Byte  = 8'hEE;
    bus.i_TX_Count = CW'(2);
    tick();
    bus.i_TX_DV = 1'b0;
  endtask

  task automatic txn_begin();
    snap_e = eng_dv_cnt;
    snap_r = cs_rise_cnt;
    snap_f = cs_fall_cnt;
  endtask

  task automatic txn_end(input int nexp, input logic [7:0] rx0, input string name);
    int  t = 0;
    int  hi;
    bit  first = 1'b1;
    rx_t e;
    stray({name, " stray_mid"});
    while (bus.o_SPI_CS_n !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    if (bus.o_SPI_CS_n !== 1'b1) begin
      timeout_fail({name, " cs_rise"});
      return;
    end
    hi = 1;
    stray({name, " stray_gap"});
    hi++;
    t = 0;
    while (!bus.o_TX_Ready && t < 100) begin
      tick();
      hi++;
      t++;
    end
    chk({name, " cs_high_at_ready"}, 32'(bus.o_SPI_CS_n), 32'd1);
    chk({name, " gap_cycles"}, hi, GAP + 1);
    chk({name, " eng_dv_pulses"}, eng_dv_cnt - snap_e, nexp);
    chk({name, " cs_rises"}, cs_rise_cnt - snap_r, 1);
    chk({name, " cs_falls"}, cs_fall_cnt - snap_f, 1);
    chk({name, " rx_pulses"}, rx_seen - rd_idx, nexp);
    while (rd_idx < rx_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s rx_extra: got %0h/%0d expected none", name, obs_b[rd_idx], obs_c[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        chk({name, " rx_byte_idx"}, 32'({obs_b[rd_idx], obs_c[rd_idx]}), 32'({e.b, e.idx}));
        if (first) chk({name, " rx_first"}, 32'(obs_b[rd_idx]), 32'(rx0));
      end
      first = 1'b0;
      rd_idx++;
    end
    chk({name, " rx_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_txn(input logic [CW-1:0] cnt, input logic [7:0] first, input int nexp,
                         input logic [7:0] rx0, input string name);
    txn_begin();
    for (int i = 0; i < nexp; i++) send(8'(first + i), cnt, i, name);
    txn_end(nexp, rx0, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, rdyc, seen0, eng0, t;
    bus.i_TX_DV    = 1'b0;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_Count = '0;

    vecs[0] = '{cnt: CW'(1), first: 8'hA5, nexp: 1, rx0: 8'h5A};
    vecs[1] = '{cnt: CW'(3), first: 8'h01, nexp: 3, rx0: 8'hFE};
    vecs[2] = '{cnt: CW'(0), first: 8'h33, nexp: 1, rx0: 8'hCC};
    vecs[3] = '{cnt: CW'(4), first: 8'h10, nexp: 4, rx0: 8'hEF};
    vecs[4] = '{cnt: CW'(7), first: 8'h80, nexp: 4, rx0: 8'h7F};

    // Reset values
    #12;
    chk("rst cs_n", 32'(bus.o_SPI_CS_n), 32'd1);
    chk("rst eng_dv", 32'(bus.o_Eng_TX_DV), 32'd0);
    chk("rst eng_byte", 32'(bus.o_Eng_TX_Byte), 32'd0);
    chk("rst rx_dv", 32'(bus.o_RX_DV), 32'd0);
    chk("rst rx_byte", 32'(bus.o_RX_Byte), 32'd0);
    chk("rst rx_count", 32'(bus.o_RX_Count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle ready", 32'(bus.o_TX_Ready), 32'd1);

    for (int v = 0; v < 5; v++)
      run_txn(vecs[v].cnt, vecs[v].first, vecs[v].nexp, vecs[v].rx0, $sformatf("vec%0d", v));

    // Reset during byte 2 of 3
    txn_begin();
    send(8'h11, CW'(3), 0, "rstmid");
    send(8'h22, CW'(3), 1, "rstmid");
    repeat (5) tick();
    chk("rstmid cs_low_before", 32'(bus.o_SPI_CS_n), 32'd0);
    seen0 = rx_seen;
    eng0  = eng_dv_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid cs_n", 32'(bus.o_SPI_CS_n), 32'd1);
    chk("rstmid eng_dv", 32'(bus.o_Eng_TX_DV), 32'd0);
    chk("rstmid eng_byte", 32'(bus.o_Eng_TX_Byte), 32'd0);
    chk("rstmid rx_dv", 32'(bus.o_RX_DV), 32'd0);
    chk("rstmid rx_byte", 32'(bus.o_RX_Byte), 32'd0);
    chk("rstmid rx_count", 32'(bus.o_RX_Count), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rstmid no_partial_rx", rx_seen - seen0, 0);
    chk("rstmid no_eng_dv", eng_dv_cnt - eng0, 0);
    rd_idx = rx_seen;
    exp_q.delete();
    run_txn(CW'(1), 8'h3C, 1, 8'hC3, "postrst");

    // Host stall between bytes
    txn_begin();
    send(8'h5C, CW'(2), 0, "stall");
    stray("stall dv_cycle");
    t = 0;
    while (!bus.o_TX_Ready && t < 100) begin
      tick();
      t++;
    end
    lowc = 0;
    rdyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_SPI_CS_n == 1'b0) lowc++;
      if (bus.o_TX_Ready) rdyc++;
      tick();
    end
    chk("stall cs_low_cycles", lowc, 100);
    chk("stall ready_cycles", rdyc, 100);
    send(8'h77, CW'(2), 1, "stall");
    txn_end(2, 8'hA3, "stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
